// File: rtl/sha256_padder_if.sv
// Byte-stream input and sha256_core block handshake bundled for the padder.
// The slave modport is the padder's view; the master modport is the
// producer/consumer environment around it.
interface sha256_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         core_ready;
    logic [511:0] message_block;
    logic         start;
    logic         first_block;
    logic         last_block;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_empty,
        input  core_ready,
        output in_ready,
        output message_block,
        output start,
        output first_block,
        output last_block
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output in_empty,
        output core_ready,
        input  in_ready,
        input  message_block,
        input  start,
        input  first_block,
        input  last_block
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects a byte stream into 64-byte blocks,
// appends 0x80, zero fill and the 64-bit big-endian bit length, and hands
// each block to sha256_core with first/last markers. The working buffer
// refills while the core hashes the previously latched block.
module sha256_padder (
    input  logic             clk,
    input  logic             rst,
    sha256_padder_if.slave   bus
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        SEND  = 2'd2,
        EXTRA = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [511:0]   buf_r;           // block under construction, byte 0 at [511:504]
    logic [6:0]     idx_r;           // next byte position, reaches 64 on a full block
    logic [60:0]    cnt_r;           // message length in bytes
    logic           first_pend_r;    // next block sent is the first of its message
    logic           armed_r;         // core has dropped ready since our last start
    logic           extra_r;         // a length-only block must follow this one
    logic           p64_r;           // message ended exactly on a block boundary
    logic           blk_first_r;     // first flag of the block waiting in SEND
    logic           blk_last_r;      // last flag of the block waiting in SEND

    logic           in_ready_r;
    logic           start_r;
    logic           first_block_r;
    logic           last_block_r;
    logic [511:0]   message_block_r;

    logic           accept_s;
    logic           write_s;
    logic           fire_s;
    logic [63:0]    len_s;

    // Overwrite byte 'pos' (0 = most significant) of a block.
    function automatic logic [511:0] put_byte(
        input logic [511:0] blk,
        input logic [6:0]   pos,
        input logic [7:0]   b
    );
        logic [511:0] r;
        r = blk;
        for (int i = 0; i < 64; i++) begin
            r[511 - 8*i -: 8] = (pos == 7'(i)) ? b : r[511 - 8*i -: 8];
        end
        return r;
    endfunction

    // Place the bit-length field in bytes 56..63.
    function automatic logic [511:0] put_len(
        input logic [511:0] blk,
        input logic [63:0]  len
    );
        return {blk[511:64], len};
    endfunction

    assign accept_s = (state_r == FILL) && in_ready_r && bus.in_valid;
    // An empty terminating beat carries no byte.
    assign write_s  = accept_s && !(bus.in_last && bus.in_empty);
    assign fire_s   = (state_r == SEND) && bus.core_ready && armed_r;
    assign len_s    = {cnt_r, 3'b000};

    assign bus.in_ready      = in_ready_r;
    assign bus.start         = start_r;
    assign bus.first_block   = first_block_r;
    assign bus.last_block    = last_block_r;
    assign bus.message_block = message_block_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL: begin
                if (accept_s && bus.in_last) begin
                    state_s = PAD;
                end else if (accept_s && (idx_r == 7'd63)) begin
                    state_s = SEND;
                end else begin
                    state_s = FILL;
                end
            end
            PAD: begin
                state_s = SEND;
            end
            SEND: begin
                if (fire_s) begin
                    state_s = extra_r ? EXTRA : FILL;
                end else begin
                    state_s = SEND;
                end
            end
            EXTRA: begin
                state_s = SEND;
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // Buffer construction, counters, handshake arming and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r           <= 512'd0;
            idx_r           <= 7'd0;
            cnt_r           <= 61'd0;
            first_pend_r    <= 1'b1;
            armed_r         <= 1'b1;
            extra_r         <= 1'b0;
            p64_r           <= 1'b0;
            blk_first_r     <= 1'b0;
            blk_last_r      <= 1'b0;
            in_ready_r      <= 1'b0;
            start_r         <= 1'b0;
            first_block_r   <= 1'b0;
            last_block_r    <= 1'b0;
            message_block_r <= 512'd0;
        end else begin
            in_ready_r <= (state_s == FILL);
            start_r    <= 1'b0;

            // A stale ready cannot launch a second start: the core must
            // first be seen busy.
            if (fire_s) begin
                armed_r <= 1'b0;
            end else if (!armed_r && !bus.core_ready) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end

            case (state_r)
                FILL: begin
                    if (write_s) begin
                        buf_r <= put_byte(buf_r, idx_r, bus.in_data);
                        idx_r <= idx_r + 7'd1;
                        cnt_r <= cnt_r + 61'd1;
                    end
                    if (accept_s && !bus.in_last && (idx_r == 7'd63)) begin
                        blk_first_r <= first_pend_r;
                        blk_last_r  <= 1'b0;
                        extra_r     <= 1'b0;
                    end
                end
                PAD: begin
                    blk_first_r <= first_pend_r;
                    if (idx_r <= 7'd55) begin
                        buf_r      <= put_len(put_byte(buf_r, idx_r, 8'h80), len_s);
                        blk_last_r <= 1'b1;
                        extra_r    <= 1'b0;
                        p64_r      <= 1'b0;
                    end else if (idx_r <= 7'd63) begin
                        buf_r      <= put_byte(buf_r, idx_r, 8'h80);
                        blk_last_r <= 1'b0;
                        extra_r    <= 1'b1;
                        p64_r      <= 1'b0;
                    end else begin
                        blk_last_r <= 1'b0;
                        extra_r    <= 1'b1;
                        p64_r      <= 1'b1;
                    end
                end
                EXTRA: begin
                    buf_r       <= {(p64_r ? 8'h80 : 8'h00), 440'd0, len_s};
                    blk_first_r <= 1'b0;
                    blk_last_r  <= 1'b1;
                    extra_r     <= 1'b0;
                end
                SEND: begin
                    if (fire_s) begin
                        start_r         <= 1'b1;
                        message_block_r <= buf_r;
                        first_block_r   <= blk_first_r;
                        last_block_r    <= blk_last_r;
                        buf_r           <= 512'd0;
                        idx_r           <= 7'd0;
                        if (blk_last_r) begin
                            cnt_r        <= 61'd0;
                            first_pend_r <= 1'b1;
                        end else begin
                            first_pend_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    buf_r <= buf_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder with a small sha256_core handshake model.
module tb_sha256_padder;

    logic clk;
    logic rst;
    sha256_padder_if bus ();

    sha256_padder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Core model: drops ready for a few cycles after each start.
    logic core_idle_r = 1'b1;
    logic core_stall  = 1'b0;
    int   busy_r      = 0;
    logic prev_start_r = 1'b0;
    int   nstarts     = 0;
    int   consec      = 0;
    logic [511:0] blk_q[$];
    logic         first_q[$];
    logic         last_q[$];

    assign bus.core_ready = core_idle_r & ~core_stall;

    always #5 clk = ~clk;

    // Core busy model and capture of every start.
    always @(posedge clk) begin
        if (bus.start) begin
            core_idle_r <= 1'b0;
            busy_r      <= 4;
            blk_q.push_back(bus.message_block);
            first_q.push_back(bus.first_block);
            last_q.push_back(bus.last_block);
            nstarts = nstarts + 1;
            if (prev_start_r) consec = consec + 1;
        end else if (busy_r > 1) begin
            busy_r <= busy_r - 1;
        end else if (busy_r == 1) begin
            busy_r      <= 0;
            core_idle_r <= 1'b1;
        end
        prev_start_r <= bus.start;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_empty = e;
        while (!bus.in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            chk("beat_timeout", 512'(t), 512'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
    endtask

    task automatic send_rep(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            send_beat(b, (i == n - 1), 1'b0);
        end
    endtask

    task automatic send_abc();
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
    endtask

    task automatic expect_block(input string tag, input logic [511:0] eb,
                                input logic ef, input logic el);
        int t;
        t = 0;
        while (blk_q.size() == 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_present"}, 512'(blk_q.size() > 0), 512'd1);
        if (blk_q.size() > 0) begin
            chk({tag, "_block"}, blk_q.pop_front(), eb);
            chk({tag, "_first"}, 512'(first_q.pop_front()), 512'(ef));
            chk({tag, "_last"},  512'(last_q.pop_front()),  512'(el));
        end
    endtask

    task automatic expect_quiet(input string tag);
        repeat (20) @(negedge clk);
        chk({tag, "_no_extra_start"}, 512'(blk_q.size()), 512'd0);
    endtask

    logic [511:0] mb0;
    int           n0;
    logic         seen_ready;
    logic         mb_moved;

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", 512'(bus.in_ready), 512'd0);
        chk("rst_start", 512'(bus.start), 512'd0);
        chk("rst_first", 512'(bus.first_block), 512'd0);
        chk("rst_last", 512'(bus.last_block), 512'd0);
        chk("rst_block", bus.message_block, 512'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 512'(bus.in_ready), 512'd1);

        // Empty message.
        send_beat(8'h00, 1'b1, 1'b1);
        expect_block("empty", {8'h80, 504'd0}, 1'b1, 1'b1);
        expect_quiet("empty");

        // "abc".
        send_abc();
        expect_block("abc", {24'h616263, 8'h80, 416'd0, 64'h18}, 1'b1, 1'b1);
        expect_quiet("abc");

        // 55 bytes: pad and length fit in one block.
        send_rep(55, 8'h61);
        expect_block("a55", {{55{8'h61}}, 8'h80, 64'h1B8}, 1'b1, 1'b1);
        expect_quiet("a55");

        // 56 bytes: length spills into an extra block.
        send_rep(56, 8'h61);
        expect_block("a56_b1", {{56{8'h61}}, 8'h80, 56'd0}, 1'b1, 1'b0);
        expect_block("a56_b2", {448'd0, 64'h1C0}, 1'b0, 1'b1);
        expect_quiet("a56");

        // 64 bytes: full data block, then 0x80 + length block.
        send_rep(64, 8'h61);
        expect_block("a64_b1", {64{8'h61}}, 1'b1, 1'b0);
        expect_block("a64_b2", {8'h80, 440'd0, 64'h200}, 1'b0, 1'b1);
        expect_quiet("a64");

        // Core holds ready low with a block pending.
        core_stall = 1'b1;
        send_abc();
        mb0        = bus.message_block;
        n0         = nstarts;
        seen_ready = 1'b0;
        mb_moved   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) seen_ready = 1'b1;
            if (bus.message_block !== mb0) mb_moved = 1'b1;
        end
        chk("stall_no_start", 512'(nstarts - n0), 512'd0);
        chk("stall_in_ready_low", 512'(seen_ready), 512'd0);
        chk("stall_block_stable", 512'(mb_moved), 512'd0);
        core_stall = 1'b0;
        expect_block("stall_abc", {24'h616263, 8'h80, 416'd0, 64'h18}, 1'b1, 1'b1);
        expect_quiet("stall");

        // Reset in the middle of a message.
        for (int i = 0; i < 20; i++) begin
            send_beat(8'h5A, 1'b0, 1'b0);
        end
        n0  = nstarts;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 512'(bus.in_ready), 512'd0);
        chk("midrst_block", bus.message_block, 512'd0);
        chk("midrst_first", 512'(bus.first_block), 512'd0);
        chk("midrst_last", 512'(bus.last_block), 512'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_back", 512'(bus.in_ready), 512'd1);
        repeat (20) @(negedge clk);
        chk("midrst_no_start", 512'(nstarts - n0), 512'd0);
        send_abc();
        expect_block("post_rst_abc", {24'h616263, 8'h80, 416'd0, 64'h18}, 1'b1, 1'b1);
        expect_quiet("post_rst");

        chk("no_back_to_back_start", 512'(consec), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
